mem_responder: RTL

Shared-memory responder for the multi-cycle 8-bit CPU. It answers the CPU's instruction-fetch and data-access requests over a req/ack handshake. It replaces the free-running strobe-clocked instruction and data memories with one synchronous 8-bit-wide array behind a round-robin arbiter. It sits between the CPU core and the storage array, and is the only block that reads or writes program and data memory.

---
 rtl/mem_resp_pkg.sv | 18 +
 rtl/mem_rr_arbiter.sv | 36 +++
 rtl/mem_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared constants for the CPU memory responder: widths, port ids and FSM state encodings.
package mem_resp_pkg;

   localparam int unsigned DataW = 8;
   localparam int unsigned AddrW = 8;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StAccess = 2'd1;
   localparam logic [1:0] StResp   = 2'd2;

   function automatic logic addr_in_range(input logic [AddrW-1:0] addr, input int unsigned depth);
      return 32'(addr) < depth;
   endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-port round-robin arbiter: combinational grant plus the registered last_grant bit.
module mem_rr_arbiter
   import mem_resp_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_req_i,
   input  logic d_req_i,
   input  logic grant_take_i,
   output logic grant_valid_o,
   output logic grant_port_o
);

   logic last_grant_q;

   always_comb begin
      grant_valid_o = i_req_i | d_req_i;
      if (i_req_i && d_req_i) begin
         grant_port_o = ~last_grant_q;
      end else if (d_req_i) begin
         grant_port_o = PORT_D;
      end else begin
         grant_port_o = PORT_I;
      end
   end

   // Resets to D so the first contention is won by the fetch port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= PORT_D;
      end else if (grant_take_i && grant_valid_o) begin
         last_grant_q <= grant_port_o;
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Shared instruction/data memory responder behind a round-robin arbiter.
// Define MEM_WAIT_EN to honour WAIT_CYCLES extra access cycles per transaction.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter string       INIT_FILE   = ""
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req,
   input  logic [AddrW-1:0] i_addr,
   output logic             i_ack,
   output logic [DataW-1:0] i_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [AddrW-1:0] d_addr,
   input  logic [DataW-1:0] d_wdata,
   output logic             d_ack,
   output logic [DataW-1:0] d_rdata,
   output logic             err
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [1:0]       state_q, state_d;
   logic             port_q;
   logic [AddrW-1:0] addr_q;
   logic             we_q;
   logic [DataW-1:0] wdata_q;
   logic             i_ack_q, d_ack_q, err_q;
   logic [DataW-1:0] i_rdata_q, d_rdata_q;
   logic [DataW-1:0] mem_q [DEPTH];

   logic             grant_valid, grant_port, grant_take;
   logic             access_fire, wait_done, in_range;
   logic [IdxW-1:0]  idx;
   logic [DataW-1:0] rd_data;

   mem_rr_arbiter u_arbiter (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req_i       (i_req),
      .d_req_i       (d_req),
      .grant_take_i  (grant_take),
      .grant_valid_o (grant_valid),
      .grant_port_o  (grant_port)
   );

`ifdef MEM_WAIT_EN
   logic [3:0] wait_q, wait_d;

   assign wait_done = (wait_q == 4'(WAIT_CYCLES));

   always_comb begin
      wait_d = wait_q;
      if (grant_take) begin
         wait_d = '0;
      end else if (state_q == StAccess && !wait_done) begin
         wait_d = wait_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end
`else
   assign wait_done = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      grant_take  = 1'b0;
      access_fire = 1'b0;
      case (state_q)
         StIdle: begin
            if (grant_valid) begin
               grant_take = 1'b1;
               state_d    = StAccess;
            end
         end
         StAccess: begin
            if (wait_done) begin
               access_fire = 1'b1;
               state_d     = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign in_range = addr_in_range(addr_q, DEPTH);
   assign idx      = addr_q[IdxW-1:0];
   assign rd_data  = in_range ? mem_q[idx] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         port_q    <= PORT_I;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         err_q     <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (grant_take) begin
            port_q  <= grant_port;
            addr_q  <= (grant_port == PORT_D) ? d_addr : i_addr;
            we_q    <= (grant_port == PORT_D) && d_we;
            wdata_q <= d_wdata;
         end
         i_ack_q <= access_fire && (port_q == PORT_I);
         d_ack_q <= access_fire && (port_q == PORT_D);
         err_q   <= access_fire && !in_range;
         if (access_fire) begin
            if (port_q == PORT_I) begin
               i_rdata_q <= rd_data;
            end else begin
               d_rdata_q <= we_q ? '0 : rd_data;
            end
         end
      end
   end

   // No reset on the array; state_q is reset asynchronously so a reset before the
   // final ACCESS edge suppresses the write.
   always_ff @(posedge clk) begin
      if (access_fire && we_q && in_range) begin
         mem_q[idx] <= wdata_q;
      end
   end

   assign i_ack   = i_ack_q;
   assign d_ack   = d_ack_q;
   assign err     = err_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;

endmodule
